// File: rtl/pdp8_pkg.sv
// Shared PDP-8 constants: word width, memory-arbiter states and owner codes.
// Also carries the request bundle used to mux a port onto the memory bus.
package pdp8_pkg;

  localparam int WORD_W = 12;

  localparam logic [2:0] SEL_PC  = 3'd0;
  localparam logic [2:0] SEL_MA  = 3'd1;
  localparam logic [2:0] SEL_MB  = 3'd2;
  localparam logic [2:0] SEL_AC  = 3'd3;

  localparam logic [1:0] CTL_NOP = 2'd0;
  localparam logic [1:0] CTL_RD  = 2'd1;
  localparam logic [1:0] CTL_WR  = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_CPU = 2'd1,
    GRANT_DB  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DB   = 2'b10
  } owner_t;

  typedef struct packed {
    logic              read;
    logic              write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

  function automatic mem_req_t pack_req(
    input logic              rd,
    input logic              wr,
    input logic [WORD_W-1:0] addr,
    input logic [WORD_W-1:0] wdata
  );
    mem_req_t r;
    r.read  = rd;
    r.write = wr;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// Grant-duration counter: expired is high in the CYCLES-th cycle of a run.
// Only instantiated when MEM_ARBITER_TIMEOUT_EN is defined.
module mem_arbiter_timer #(
  parameter int CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between the CPU and the data-break port.
// Define MEM_ARBITER_TIMEOUT_EN to abort grants that last TIMEOUT_CYCLES.
module mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int DB_BURST       = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [11:0] cpu_addr,
  input  logic [11:0] cpu_wdata,
  output logic [11:0] cpu_rdata,
  output logic        cpu_valid,
  input  logic        db_read,
  input  logic        db_write,
  input  logic [11:0] db_addr,
  input  logic [11:0] db_wdata,
  output logic [11:0] db_rdata,
  output logic        db_valid,
  output logic        mem_read,
  output logic        mem_write,
  output logic [11:0] mem_addr,
  output logic [11:0] mem_wdata,
  input  logic [11:0] mem_rdata,
  input  logic        mem_valid,
  output logic [1:0]  owner,
  output logic        timeout_err
);

  localparam int BW = $clog2(DB_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(DB_BURST);

  arb_state_t     state, state_nx;
  logic [BW-1:0]  burst;
  logic           cpu_req, db_req, grant, expired;
  mem_req_t       sel;
  logic [11:0]    rdata;

  assign cpu_req = cpu_read | cpu_write;
  assign db_req  = db_read | db_write;
  assign grant   = (state != IDLE);

  always_comb begin : cfg_check
    assert (DB_BURST > 0 && TIMEOUT_CYCLES > 0);
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  mem_arbiter_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (grant),
    .clear   (!grant),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // DB wins in IDLE until it has taken BMAX grants in a row over a waiting CPU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst <= '0;
    end else if (!cpu_req) begin
      burst <= '0;
    end else if (!grant && state_nx == GRANT_CPU) begin
      burst <= '0;
    end else if (!grant && state_nx == GRANT_DB && burst != BMAX) begin
      burst <= burst + 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    sel         = '0;
    rdata       = '0;
    owner       = OWN_NONE;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    cpu_valid   = 1'b0;
    cpu_rdata   = '0;
    db_valid    = 1'b0;
    db_rdata    = '0;
    timeout_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (db_req && !(cpu_req && burst == BMAX)) begin
          state_nx = GRANT_DB;
        end else if (cpu_req) begin
          state_nx = GRANT_CPU;
        end
      end
      GRANT_CPU: begin
        sel   = pack_req(cpu_read, cpu_write, cpu_addr, cpu_wdata);
        owner = OWN_CPU;
      end
      GRANT_DB: begin
        sel   = pack_req(db_read, db_write, db_addr, db_wdata);
        owner = OWN_DB;
      end
      default: state_nx = IDLE;
    endcase
    if (grant) begin
      mem_write = sel.write & ~expired;
      mem_read  = sel.read & ~sel.write & ~expired;
      mem_addr  = sel.addr;
      mem_wdata = sel.wdata;
      if (!(sel.read | sel.write)) begin
        state_nx = IDLE;
      end else if (mem_valid | expired) begin
        state_nx    = IDLE;
        timeout_err = ~mem_valid;
        rdata       = mem_valid ? mem_rdata : '0;
        cpu_valid   = (state == GRANT_CPU);
        db_valid    = (state == GRANT_DB);
        cpu_rdata   = cpu_valid ? rdata : '0;
        db_rdata    = db_valid ? rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a random run
// against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int DBB = 4;
  localparam int TOC = 8;
`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_read, cpu_write, db_read, db_write;
  logic [11:0] cpu_addr, cpu_wdata, db_addr, db_wdata;
  logic [11:0] cpu_rdata, db_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_valid, db_valid, mem_read, mem_write, mem_valid;
  logic [1:0]  owner;
  logic        timeout_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .DB_BURST       (DBB),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_read    (cpu_read),
    .cpu_write   (cpu_write),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_valid   (cpu_valid),
    .db_read     (db_read),
    .db_write    (db_write),
    .db_addr     (db_addr),
    .db_wdata    (db_wdata),
    .db_rdata    (db_rdata),
    .db_valid    (db_valid),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .owner       (owner),
    .timeout_err (timeout_err)
  );

  task automatic clear_inputs();
    cpu_read = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
    db_read = 0; db_write = 0; db_addr = '0; db_wdata = '0;
    mem_valid = 0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    logic [59:0] outs;
    rst_n = 0; cpu_read = 1; db_write = 1; mem_valid = 1; mem_rdata = '1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (owner !== 2'b00) begin
      bad++; $display("FAIL reset_owner got=%0h want=0", owner);
    end
    total++;
    if ({mem_read, mem_write, cpu_valid, db_valid, timeout_err} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes got=%b want=0",
        {mem_read, mem_write, cpu_valid, db_valid, timeout_err});
    end
    outs = {mem_addr, mem_wdata, cpu_rdata, db_rdata, 12'h000};
    total++;
    if (outs !== 60'h0) begin
      bad++; $display("FAIL reset_data got=%0h want=0", outs);
    end
    db_write = 0; mem_valid = 0; mem_rdata = '0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total++;
    if (owner !== 2'b01) begin
      bad++; $display("FAIL reset_first_arb got=%0h want=1", owner);
    end
    mem_valid = 1; mem_rdata = 12'o1111;
    #1;
    total++;
    if (cpu_valid !== 1'b1 || cpu_rdata !== 12'o1111) begin
      bad++; $display("FAIL reset_first_txn got=%b/%0o want=1/1111",
        cpu_valid, cpu_rdata);
    end
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    total++;
    if (owner !== 2'b00) begin
      bad++; $display("FAIL reset_back_idle got=%0h want=0", owner);
    end
  endtask

  task automatic test_cpu_read();
    @(posedge clk); #1;
    cpu_read = 1; cpu_addr = 12'o0200;
    @(negedge clk);
    total++;
    if (owner !== 2'b00 || mem_read !== 1'b0) begin
      bad++; $display("FAIL cpu_read_idle got=%0h/%b want=0/0", owner, mem_read);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (owner !== 2'b01 || mem_read !== 1'b1 || mem_addr !== 12'o0200) begin
      bad++; $display("FAIL cpu_read_grant got=%0h/%b/%0o want=1/1/200",
        owner, mem_read, mem_addr);
    end
    total++;
    if (cpu_valid !== 1'b0) begin
      bad++; $display("FAIL cpu_read_early_valid got=%b want=0", cpu_valid);
    end
    @(posedge clk); #1;
    mem_valid = 1; mem_rdata = 12'o7402;
    @(negedge clk);
    total++;
    if (cpu_valid !== 1'b1 || cpu_rdata !== 12'o7402 || db_valid !== 1'b0) begin
      bad++; $display("FAIL cpu_read_data got=%b/%0o/%b want=1/7402/0",
        cpu_valid, cpu_rdata, db_valid);
    end
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    total++;
    if (owner !== 2'b00 || cpu_valid !== 1'b0 || cpu_rdata !== 12'o0) begin
      bad++; $display("FAIL cpu_read_done got=%0h/%b/%0o want=0/0/0",
        owner, cpu_valid, cpu_rdata);
    end
  endtask

  task automatic test_same_cycle();
    @(posedge clk); #1;
    cpu_read = 1; cpu_addr = 12'o0321;
    db_read = 1; db_addr = 12'o0456;
    @(posedge clk); #1;
    mem_valid = 1; mem_rdata = 12'o5555;
    @(negedge clk);
    total++;
    if (owner !== 2'b10 || mem_addr !== 12'o0456) begin
      bad++; $display("FAIL same_cycle_owner got=%0h/%0o want=2/456", owner, mem_addr);
    end
    total++;
    if (db_valid !== 1'b1 || db_rdata !== 12'o5555 || cpu_valid !== 1'b0 ||
        cpu_rdata !== 12'o0) begin
      bad++; $display("FAIL same_cycle_db_first got=%b/%0o/%b/%0o want=1/5555/0/0",
        db_valid, db_rdata, cpu_valid, cpu_rdata);
    end
    @(posedge clk); #1;
    db_read = 0; mem_valid = 0;
    @(posedge clk); #1;
    mem_valid = 1; mem_rdata = 12'o6666;
    @(negedge clk);
    total++;
    if (owner !== 2'b01 || cpu_valid !== 1'b1 || cpu_rdata !== 12'o6666) begin
      bad++; $display("FAIL same_cycle_cpu_next got=%0h/%b/%0o want=1/1/6666",
        owner, cpu_valid, cpu_rdata);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_burst();
    logic [1:0] grants[$];
    logic [1:0] want;
    int cyc;
    @(posedge clk); #1;
    cpu_read = 1; db_read = 1; mem_valid = 1; mem_rdata = 12'o0017;
    cyc = 0;
    while (grants.size() < 10 && cyc < 80) begin
      @(negedge clk);
      if (owner != 2'b00) grants.push_back(owner);
      cyc++;
    end
    total++;
    if (grants.size() != 10) begin
      bad++; $display("FAIL burst_timeout got=%0d want=10 grants", grants.size());
    end
    foreach (grants[k]) begin
      want = (k % (DBB + 1) == DBB) ? 2'b01 : 2'b10;
      total++;
      if (grants[k] !== want) begin
        bad++; $display("FAIL burst_grant%0d got=%0h want=%0h", k, grants[k], want);
      end
    end
    @(posedge clk); #1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_db_abort();
    db_write = 1; db_addr = 12'o0050; db_wdata = 12'o1234;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 12'o0050 ||
        mem_wdata !== 12'o1234) begin
      bad++; $display("FAIL db_abort_write got=%b/%b/%0o/%0o want=1/0/50/1234",
        mem_write, mem_read, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    db_write = 0;
    #1;
    total++;
    if (mem_write !== 1'b0 || db_valid !== 1'b0 || owner !== 2'b10) begin
      bad++; $display("FAIL db_abort_drop got=%b/%b/%0h want=0/0/2",
        mem_write, db_valid, owner);
    end
    @(negedge clk);
    @(posedge clk); #1;
    total++;
    if (owner !== 2'b00 || db_valid !== 1'b0) begin
      bad++; $display("FAIL db_abort_idle got=%0h/%b want=0/0", owner, db_valid);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_grant();
    int vhits;
    @(posedge clk); #1;
    cpu_read = 1; cpu_addr = 12'o0777;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (mem_read !== 1'b1 || owner !== 2'b01) begin
      bad++; $display("FAIL midreset_pre got=%b/%0h want=1/1", mem_read, owner);
    end
    #2;
    rst_n = 0;
    #1;
    total++;
    if (mem_read !== 1'b0 || owner !== 2'b00 || cpu_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_async got=%b/%0h/%b want=0/0/0",
        mem_read, owner, cpu_valid);
    end
    cpu_read = 0; mem_valid = 1; mem_rdata = 12'o4321;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    vhits = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_valid !== 1'b0 || owner !== 2'b00) vhits++;
    end
    total++;
    if (vhits != 0) begin
      bad++; $display("FAIL midreset_after got=%0d want=0 bad cycles", vhits);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_timeout();
    int errs;
    @(posedge clk); #1;
    cpu_read = 1; cpu_addr = 12'o0100; mem_valid = 0;
    @(posedge clk); #1;
    if (TO_EN) begin
      for (int i = 1; i <= TOC; i++) begin
        @(negedge clk);
        if (i < TOC) begin
          total++;
          if (cpu_valid !== 1'b0 || timeout_err !== 1'b0 || mem_read !== 1'b1) begin
            bad++; $display("FAIL timeout_wait%0d got=%b/%b/%b want=0/0/1",
              i, cpu_valid, timeout_err, mem_read);
          end
          @(posedge clk);
        end else begin
          total++;
          if (cpu_valid !== 1'b1 || timeout_err !== 1'b1 || cpu_rdata !== 12'o0 ||
              mem_read !== 1'b0) begin
            bad++; $display("FAIL timeout_fire got=%b/%b/%0o/%b want=1/1/0/0",
              cpu_valid, timeout_err, cpu_rdata, mem_read);
          end
        end
      end
      @(posedge clk); #1;
      cpu_read = 0;
      @(negedge clk);
      total++;
      if (owner !== 2'b00 || timeout_err !== 1'b0) begin
        bad++; $display("FAIL timeout_idle got=%0h/%b want=0/0", owner, timeout_err);
      end
    end else begin
      errs = 0;
      repeat (110) begin
        @(negedge clk);
        if (timeout_err !== 1'b0 || owner !== 2'b01 || cpu_valid !== 1'b0 ||
            mem_read !== 1'b1) errs++;
      end
      total++;
      if (errs != 0) begin
        bad++; $display("FAIL timeout_hold got=%0d want=0 bad cycles", errs);
      end
    end
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int m_owner, m_age, m_dbrun;
    bit c_busy, d_busy, c_done, d_done;
    bit o_rd, o_wr, o_req, act, late, fin;
    bit e_mr, e_mw, e_cv, e_dv, e_err, c_req, d_req;
    logic [11:0] o_addr, o_wd, e_data, e_cr, e_dr;
    int kind;
    rst_n = 0;
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1;
    m_owner = 0; m_age = 0; m_dbrun = 0;
    c_busy = 0; d_busy = 0; c_done = 0; d_done = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (c_busy && (c_done || $urandom_range(0, 49) == 0)) begin
        c_busy = 0; cpu_read = 0; cpu_write = 0;
      end else if (!c_busy && $urandom_range(0, 2) == 0) begin
        c_busy = 1; kind = $urandom_range(0, 2);
        cpu_read = (kind != 1); cpu_write = (kind != 0);
        cpu_addr = 12'($urandom); cpu_wdata = 12'($urandom);
      end
      if (d_busy && (d_done || $urandom_range(0, 49) == 0)) begin
        d_busy = 0; db_read = 0; db_write = 0;
      end else if (!d_busy && $urandom_range(0, 2) == 0) begin
        d_busy = 1; kind = $urandom_range(0, 2);
        db_read = (kind != 1); db_write = (kind != 0);
        db_addr = 12'($urandom); db_wdata = 12'($urandom);
      end
      mem_valid = ($urandom_range(0, 2) == 0);
      mem_rdata = 12'($urandom);
      @(negedge clk);
      c_req = cpu_read | cpu_write;
      d_req = db_read | db_write;
      o_rd = 0; o_wr = 0; o_addr = '0; o_wd = '0;
      if (m_owner == 1) begin
        o_rd = cpu_read; o_wr = cpu_write; o_addr = cpu_addr; o_wd = cpu_wdata;
      end else if (m_owner == 2) begin
        o_rd = db_read; o_wr = db_write; o_addr = db_addr; o_wd = db_wdata;
      end
      act = (m_owner != 0);
      o_req = o_rd | o_wr;
      late = TO_EN && act && (m_age == TOC);
      e_mw = act && o_wr && !late;
      e_mr = act && o_rd && !o_wr && !late;
      fin = act && o_req && (mem_valid || late);
      e_err = fin && !mem_valid;
      e_data = mem_valid ? mem_rdata : 12'o0;
      e_cv = fin && (m_owner == 1);
      e_dv = fin && (m_owner == 2);
      e_cr = e_cv ? e_data : 12'o0;
      e_dr = e_dv ? e_data : 12'o0;
      total++;
      if (owner !== 2'(m_owner)) begin
        bad++; $display("FAIL rnd_owner c%0d got=%0h want=%0h", cyc, owner, m_owner);
      end
      total++;
      if ({mem_read, mem_write} !== {e_mr, e_mw}) begin
        bad++; $display("FAIL rnd_strobe c%0d got=%b%b want=%b%b",
          cyc, mem_read, mem_write, e_mr, e_mw);
      end
      if (e_mr || e_mw) begin
        total++;
        if (mem_addr !== o_addr || (e_mw && mem_wdata !== o_wd)) begin
          bad++; $display("FAIL rnd_bus c%0d got=%0o/%0o want=%0o/%0o",
            cyc, mem_addr, mem_wdata, o_addr, o_wd);
        end
      end
      total++;
      if ({cpu_valid, db_valid, timeout_err} !== {e_cv, e_dv, e_err}) begin
        bad++; $display("FAIL rnd_valid c%0d got=%b%b%b want=%b%b%b",
          cyc, cpu_valid, db_valid, timeout_err, e_cv, e_dv, e_err);
      end
      total++;
      if (cpu_rdata !== e_cr || db_rdata !== e_dr) begin
        bad++; $display("FAIL rnd_rdata c%0d got=%0o/%0o want=%0o/%0o",
          cyc, cpu_rdata, db_rdata, e_cr, e_dr);
      end
      c_done = e_cv;
      d_done = e_dv;
      if (act) begin
        if (!o_req || fin) begin
          m_owner = 0; m_age = 0;
        end else begin
          m_age++;
        end
      end else if (d_req && !(c_req && m_dbrun == DBB)) begin
        m_owner = 2; m_age = 1;
        m_dbrun = c_req ? ((m_dbrun < DBB) ? m_dbrun + 1 : DBB) : 0;
      end else if (c_req) begin
        m_owner = 1; m_age = 1; m_dbrun = 0;
      end
      if (!c_req) m_dbrun = 0;
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_cpu_read();
    test_same_cycle();
    test_burst();
    test_db_abort();
    test_reset_mid_grant();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
